// File: rtl/instr_feeder.sv
// Program sequencer feeding a multicycle processor: holds a loadable program memory,
// issues one instruction per Run pulse and waits for Done before fetching the next.
module instr_feeder #(
    parameter int AW      = 5,
    parameter int W       = 9,
    parameter int TIMEOUT = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_end_addr,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [W-1:0]  i_ld_data,
    input  logic          i_done,
    output logic [W-1:0]  o_din,
    output logic          o_run,
    output logic          o_busy,
    output logic          o_halted,
    output logic          o_err,
    output logic [AW-1:0] o_pc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_ptr;
    logic [AW-1:0] r_end;
    logic [2:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [W-1:0]  r_mem [2**AW];

    logic          w_loadable;
    logic [W-1:0]  w_word;
    logic          w_imm;
    logic [AW:0]   w_nxt;

    assign w_loadable = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_word     = r_mem[r_ptr[AW-1:0]];
    assign w_imm      = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b101);
    // The extra pointer bit makes running past the last address visible as a value above EndAddr.
    assign w_nxt      = r_ptr + {{AW{1'b0}}, w_imm};

    always_ff @(posedge i_clk) begin
        if (w_loadable && i_ld_en) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_end   <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        r_end   <= i_end_addr;
                        r_ptr   <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_op    <= w_word[W-1 -: 3];
                    r_ptr   <= r_ptr + {{AW{1'b0}}, 1'b1};
                    r_cnt   <= '0;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (i_done) begin
                        if (w_nxt > {1'b0, r_end}) begin
                            r_state <= S_HALT;
                        end else begin
                            r_ptr   <= w_nxt;
                            r_state <= S_ISSUE;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_run    = (r_state == S_ISSUE);
    assign o_busy   = (r_state == S_ISSUE) || (r_state == S_EXEC);
    assign o_halted = (r_state == S_HALT);
    assign o_err    = r_err;
    assign o_pc     = r_ptr[AW-1:0];
    assign o_din    = o_busy ? w_word : '0;

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: a program-walking reference builds the expected
// per-cycle output trace, a responder drives Done, and random programs/noise exercise it.
module tb_instr_feeder;

    localparam int AW      = 5;
    localparam int W       = 9;
    localparam int TIMEOUT = 7;
    localparam int DEPTH   = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_end_addr;
    logic          i_ld_en;
    logic [AW-1:0] i_ld_addr;
    logic [W-1:0]  i_ld_data;
    logic          i_done;
    logic [W-1:0]  o_din;
    logic          o_run;
    logic          o_busy;
    logic          o_halted;
    logic          o_err;
    logic [AW-1:0] o_pc;

    always #5 clk = ~clk;

    instr_feeder #(.AW(AW), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_end_addr (i_end_addr),
        .i_ld_en    (i_ld_en),
        .i_ld_addr  (i_ld_addr),
        .i_ld_data  (i_ld_data),
        .i_done     (i_done),
        .o_din      (o_din),
        .o_run      (o_run),
        .o_busy     (o_busy),
        .o_halted   (o_halted),
        .o_err      (o_err),
        .o_pc       (o_pc)
    );

    typedef struct packed {
        logic          run;
        logic          busy;
        logic          halted;
        logic          err;
        logic [AW-1:0] pc;
        logic [W-1:0]  din;
        logic          done;
    } exp_t;

    logic [W-1:0]  mem [DEPTH];
    exp_t          trace[$];
    int            delays[$];
    logic [AW-1:0] runPcs[$];
    logic [W-1:0]  dutDin[$];
    exp_t          restExp;
    logic [AW-1:0] finalPc;
    logic          finalErr;
    logic [AW-1:0] lastPc;
    logic          lastErr;
    int            vectors = 0;
    int            miscompares = 0;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input exp_t e, input string name);
        vectors++;
        if ({o_run, o_busy, o_halted, o_err, o_pc, o_din} !== {e.run, e.busy, e.halted, e.err, e.pc, e.din}) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got run=%b busy=%b halted=%b err=%b pc=%0d din=%h, want run=%b busy=%b halted=%b err=%b pc=%0d din=%h",
                     name, $time, o_run, o_busy, o_halted, o_err, o_pc, o_din,
                     e.run, e.busy, e.halted, e.err, e.pc, e.din);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Walk the program the way the spec describes it and emit one expected record per cycle.
    function automatic void buildTrace(input int endAddr);
        int   ptr = 0;
        int   k   = 0;
        int   d;
        int   n;
        int   nxt;
        logic [2:0] op;
        exp_t e;
        trace.delete();
        forever begin
            e = '0;
            e.run = 1'b1; e.busy = 1'b1;
            e.pc = AW'(ptr % DEPTH); e.din = mem[ptr % DEPTH];
            e.done = 1'($urandom_range(0, 1));
            trace.push_back(e);
            op = mem[ptr % DEPTH][W-1 -: 3];
            ptr++;
            d = (k < delays.size()) ? delays[k] : 1;
            k++;
            n = (d == 0) ? TIMEOUT : d;
            for (int j = 1; j <= n; j++) begin
                e = '0;
                e.busy = 1'b1;
                e.pc = AW'(ptr % DEPTH); e.din = mem[ptr % DEPTH];
                e.done = (j == d);
                trace.push_back(e);
            end
            if (d == 0) begin
                finalErr = 1'b1; finalPc = AW'(ptr % DEPTH);
                break;
            end
            nxt = ptr + ((op == 3'd1 || op == 3'd4 || op == 3'd5) ? 1 : 0);
            if (nxt > endAddr) begin
                finalErr = 1'b0; finalPc = AW'(ptr % DEPTH);
                break;
            end
            ptr = nxt;
        end
    endfunction

    task automatic loadWord(input int addr, input logic [W-1:0] data);
        checkOutput(restExp, "load");
        i_ld_en = 1'b1; i_ld_addr = AW'(addr); i_ld_data = data;
        @(negedge clk);
        i_ld_en = 1'b0;
        mem[addr] = data;
    endtask

    task automatic applyStimulus(input int endAddr, input bit noise, input bit ldSame,
                                 input logic [W-1:0] ldWord, input int abortAt);
        exp_t h;
        checkOutput(restExp, "pre-start");
        i_start = 1'b1; i_end_addr = AW'(endAddr);
        if (ldSame) begin
            i_ld_en = 1'b1; i_ld_addr = '0; i_ld_data = ldWord;
            mem[0] = ldWord;
        end
        buildTrace(endAddr);
        @(negedge clk);
        i_start = 1'b0; i_ld_en = 1'b0;
        runPcs.delete(); dutDin.delete();
        for (int i = 0; i < trace.size(); i++) begin
            checkOutput(trace[i], "run");
            if (o_run) runPcs.push_back(o_pc);
            dutDin.push_back(o_din);
            if (i == abortAt) begin
                i_done = 1'b0;
                rst_n = 1'b0;
                #1;
                checkOutput('0, "async reset");
                @(negedge clk);
                rst_n = 1'b1;
                restExp = '0;
                for (int c = 0; c < 4; c++) begin
                    checkOutput(restExp, "post-reset idle");
                    @(negedge clk);
                end
                return;
            end
            i_done = trace[i].done;
            if (noise) begin
                i_start    = ($urandom_range(0, 3) == 0);
                i_end_addr = AW'($urandom_range(0, DEPTH - 1));
                i_ld_en    = ($urandom_range(0, 2) == 0);
                i_ld_addr  = AW'($urandom_range(0, DEPTH - 1));
                i_ld_data  = W'($urandom_range(0, 511));
            end
            @(negedge clk);
        end
        i_start = 1'b0; i_ld_en = 1'b0;
        h = '0; h.halted = 1'b1; h.err = finalErr; h.pc = finalPc;
        restExp = h;
        lastPc = o_pc; lastErr = o_err;
        for (int c = 0; c < 3; c++) begin
            checkOutput(h, "halt");
            i_done = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        i_done = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        rst_n = 1'b0; i_start = 0; i_end_addr = 0; i_ld_en = 0; i_ld_addr = 0; i_ld_data = 0; i_done = 0;
        restExp = '0;
        repeat (2) @(negedge clk);
        checkOutput(restExp, "reset state");
        rst_n = 1'b1;
        for (int a = 0; a < DEPTH; a++) loadWord(a, '0);

        // MVI R0,#5; MV R1,R0; ADD R0,R1
        loadWord(0, 9'h040); loadWord(1, 9'h005); loadWord(2, 9'h008); loadWord(3, 9'h081);
        delays = '{1, 1, 3};
        applyStimulus(3, 0, 0, '0, -1);
        checkValue("t1 run count", runPcs.size(), 3);
        checkValue("t1 run pcs", {runPcs[0], runPcs[1], runPcs[2]}, {5'd0, 5'd2, 5'd3});
        checkValue("t1 MVI immediate", dutDin[1], 9'h005);
        checkValue("t1 halt pc", lastPc, 4);

        // Reset during the second EXEC cycle of ADD.
        applyStimulus(3, 0, 0, '0, 6);

        // Done withheld: timeout.
        loadWord(0, 9'h008);
        delays = '{0};
        applyStimulus(0, 0, 0, '0, -1);
        checkValue("t3 err", lastErr, 1);
        checkValue("t3 trace length", trace.size(), 1 + TIMEOUT);

        // Noise while busy, then the same program clean: memory must be intact.
        loadWord(0, 9'h040);
        delays = '{1, 1, 3};
        applyStimulus(3, 1, 0, '0, -1);
        checkValue("t4 err cleared", lastErr, 0);
        applyStimulus(3, 0, 0, '0, -1);
        checkValue("t4 run count", runPcs.size(), 3);

        // Full memory of MV words runs off the end without wrapping.
        for (int a = 0; a < DEPTH; a++) loadWord(a, W'($urandom_range(0, 63)));
        delays.delete();
        for (int a = 0; a < DEPTH; a++) delays.push_back(1);
        applyStimulus(DEPTH - 1, 0, 0, '0, -1);
        checkValue("t5 run count", runPcs.size(), DEPTH);
        checkValue("t5 halt pc", lastPc, 0);

        // MVIALL at EndAddr takes its immediate from EndAddr+1.
        loadWord(0, 9'h140); loadWord(1, 9'h1AB);
        delays = '{2};
        applyStimulus(0, 0, 0, '0, -1);
        checkValue("t6 immediate", dutDin[1], 9'h1AB);
        checkValue("t6 halt pc", lastPc, 1);

        for (int it = 0; it < 25; it++) begin
            for (int n = $urandom_range(0, 6); n > 0; n--)
                loadWord($urandom_range(0, DEPTH - 1), W'($urandom_range(0, 511)));
            delays.delete();
            for (int k = 0; k < DEPTH + 1; k++)
                delays.push_back(($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, TIMEOUT));
            w = W'($urandom_range(0, 511));
            applyStimulus($urandom_range(0, DEPTH - 1), 1, ($urandom_range(0, 3) == 0), w, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
